// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner: FSM encoding,
// hex glyph table (active-low, bit 0 = segment a) and anode helpers.
package seven_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF   = 7'b1111111;

    // Indexed by character value; listed from F down to 0 (gfedcba, active-low).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

    // Digit 0 is the leftmost digit and sits on an[3].
    function automatic logic [3:0] anode_for(input logic [1:0] sel);
        return ~(4'b1000 >> sel);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit character to active-low seven-segment decoder.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] shape;

    assign shape = HEX_SEG_TABLE[hex];

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_seg
            assign seg[gi] = shape[gi];
        end
    endgenerate

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed display scanner with blanking between digits and a
// rotation offset that only moves on frame boundaries.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int ROT_DIV     = 25000000,
    parameter int AUTO_ROTATE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rot_step,
    input  logic       rot_dir,
    input  logic       freeze,
    input  logic [3:0] char,
    output logic [1:0] regSel,
    output logic [3:0] rot_counter,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [ROT_W-1:0]  timer_reg;
    scan_state_t       state_reg;
    logic [1:0]        reg_sel_reg;
    logic [3:0]        rot_reg;
    logic [3:0]        an_reg;
    logic [6:0]        seg_reg;
    logic              pending_reg;

    logic       slot_wrap;
    logic       capture;
    logic       frame_end;
    logic       timer_tc;
    logic       auto_req;
    logic       rot_req;
    logic       apply_rot;
    logic [6:0] seg_decoded;

    assign slot_wrap = (slot_cnt_reg == SLOT_W'(REFRESH_DIV - 1));
    assign capture   = (slot_cnt_reg == SLOT_W'(BLANK_CYC - 1));
    assign frame_end = slot_wrap && (reg_sel_reg == 2'd3);

    assign timer_tc  = (timer_reg == ROT_W'(ROT_DIV - 1));
    assign auto_req  = (AUTO_ROTATE != 0) && !freeze && timer_tc;
    assign rot_req   = rot_step || auto_req;
    assign apply_rot = frame_end && pending_reg;

    hex_to_seg7 u_decoder (
        .hex (char),
        .seg (seg_decoded)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_reg <= '0;
        end else if (slot_wrap) begin
            slot_cnt_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
        end
    end

    // Anode and segments update on the same edge so a new glyph never lands
    // on the previous digit; the mux has had the whole blank window to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_BLANK;
            reg_sel_reg <= 2'd0;
            an_reg      <= ANODE_OFF;
            seg_reg     <= SEG_OFF;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    if (capture) begin
                        state_reg <= ST_SHOW;
                        an_reg    <= anode_for(reg_sel_reg);
                        seg_reg   <= seg_decoded;
                    end
                end
                ST_SHOW: begin
                    if (slot_wrap) begin
                        state_reg   <= ST_BLANK;
                        an_reg      <= ANODE_OFF;
                        reg_sel_reg <= reg_sel_reg + 2'd1;
                    end
                end
                default: begin
                    state_reg <= ST_BLANK;
                    an_reg    <= ANODE_OFF;
                end
            endcase
        end
    end

    // A request seen on the applying edge itself re-arms pending for next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg   <= '0;
            pending_reg <= 1'b0;
            rot_reg     <= 4'd0;
        end else begin
            if ((AUTO_ROTATE != 0) && !freeze) begin
                timer_reg <= timer_tc ? '0 : timer_reg + 1'b1;
            end
            if (apply_rot) begin
                rot_reg     <= rot_dir ? rot_reg + 4'd1 : rot_reg - 4'd1;
                pending_reg <= rot_req;
            end else if (rot_req) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign regSel      = reg_sel_reg;
    assign rot_counter = rot_reg;
    assign an          = an_reg;
    assign seg         = seg_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: per-cycle reference checks plus a
// per-slot scoreboard of expected anode/segment pairs.
module tb_seven_seg_scanner;

    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;
    localparam int ROT_DIV     = 100;
    localparam int AUTO_ROTATE = 1;

    typedef struct {
        logic [3:0] ch;
        logic [6:0] seg;
    } dec_vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] ch;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rot_step;
    logic       rot_dir;
    logic       freeze;
    logic [3:0] char_in;
    logic [1:0] reg_sel;
    logic [3:0] rot_counter;
    logic [3:0] an;
    logic [6:0] seg;

    logic       ovr_en;
    logic [3:0] ovr_char;

    dec_vec_t   dec_tab [16];
    logic [3:0] an_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    sb_entry_t  sb_q [$];
    sb_entry_t  mon_e;
    logic [3:0] an_prev = 4'hF;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         m_cnt;
    int         m_sel;
    int         m_timer;
    logic [3:0] m_rot;
    logic       m_pending;

    always #5 clk = ~clk;

    // Message multiplexer model, with an override used for the decode sweep.
    assign char_in = ovr_en ? ovr_char : 4'(reg_sel + rot_counter);

    seven_seg_scanner #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .ROT_DIV     (ROT_DIV),
        .AUTO_ROTATE (AUTO_ROTATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rot_step    (rot_step),
        .rot_dir     (rot_dir),
        .freeze      (freeze),
        .char        (char_in),
        .regSel      (reg_sel),
        .rot_counter (rot_counter),
        .an          (an),
        .seg         (seg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge: predict from current inputs, advance, then compare.
    task automatic tick();
        logic       req;
        logic       boundary;
        logic [3:0] ch;
        req      = rot_step || ((AUTO_ROTATE != 0) && !freeze && (m_timer == ROT_DIV - 1));
        boundary = (m_cnt == REFRESH_DIV - 1) && (m_sel == 3);
        if (!reset && (m_cnt == BLANK_CYC - 1)) begin
            ch = ovr_en ? ovr_char : 4'(m_sel) + m_rot;
            sb_q.push_back('{an: an_tab[m_sel], seg: dec_tab[ch].seg, ch: ch});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            m_cnt = 0; m_sel = 0; m_timer = 0; m_rot = 4'd0; m_pending = 1'b0;
            sb_q.delete();
        end else begin
            if (!freeze) m_timer = (m_timer == ROT_DIV - 1) ? 0 : m_timer + 1;
            if (boundary && m_pending) begin
                m_rot     = rot_dir ? m_rot + 4'd1 : m_rot - 4'd1;
                m_pending = req;
            end else if (req) begin
                m_pending = 1'b1;
            end
            if (m_cnt == REFRESH_DIV - 1) begin
                m_cnt = 0;
                m_sel = (m_sel + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
        check("regSel", reg_sel, m_sel);
        check("rot_counter", rot_counter, m_rot);
        check("an", an, (m_cnt >= BLANK_CYC) ? an_tab[m_sel] : 4'hF);
    endtask

    task automatic run_until(input int cnt, input int sel);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(m_cnt == cnt && (sel < 0 || m_sel == sel)) && k < 64);
        if (!(m_cnt == cnt && (sel < 0 || m_sel == sel))) check("run_until_timeout", 1, 0);
    endtask

    task automatic pulse();
        rot_step = 1'b1;
        tick();
        rot_step = 1'b0;
    endtask

    // Request one step mid-frame and run through the applying boundary edge.
    task automatic step_frame(input logic dir);
        run_until(3, 0);
        rot_dir = dir;
        pulse();
        run_until(REFRESH_DIV - 1, 3);
        tick();
    endtask

    always @(negedge clk) begin
        if (an != 4'hF && an_prev == 4'hF) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("slot_an", an, mon_e.an);
                check("slot_seg", seg, mon_e.seg);
                $display("slot cyc=%0d an=%b seg=%b char=%h", cyc, an, seg, mon_e.ch);
            end
        end
        an_prev <= an;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_tab[0]  = '{4'h0, 7'b1000000}; dec_tab[1]  = '{4'h1, 7'b1111001};
        dec_tab[2]  = '{4'h2, 7'b0100100}; dec_tab[3]  = '{4'h3, 7'b0110000};
        dec_tab[4]  = '{4'h4, 7'b0011001}; dec_tab[5]  = '{4'h5, 7'b0010010};
        dec_tab[6]  = '{4'h6, 7'b0000010}; dec_tab[7]  = '{4'h7, 7'b1111000};
        dec_tab[8]  = '{4'h8, 7'b0000000}; dec_tab[9]  = '{4'h9, 7'b0010000};
        dec_tab[10] = '{4'hA, 7'b0001000}; dec_tab[11] = '{4'hB, 7'b0000011};
        dec_tab[12] = '{4'hC, 7'b1000110}; dec_tab[13] = '{4'hD, 7'b0100001};
        dec_tab[14] = '{4'hE, 7'b0000110}; dec_tab[15] = '{4'hF, 7'b0001110};

        m_cnt = 0; m_sel = 0; m_timer = 0; m_rot = 4'd0; m_pending = 1'b0;
        reset = 1'b1; rot_step = 1'b0; rot_dir = 1'b1; freeze = 1'b1;
        ovr_en = 1'b0; ovr_char = 4'd0;

        // Reset values and first lit digit
        repeat (3) tick();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_regSel", reg_sel, 0);
        check("rst_rot", rot_counter, 0);
        reset = 1'b0;
        tick();
        check("first_blank_an", an, 4'hF);
        tick();
        check("first_an", an, 4'b0111);
        check("first_seg", seg, 7'b1000000);

        // Scan order over the first frame
        run_until(BLANK_CYC, 3);
        check("digit3_seg", seg, 7'b0110000);
        run_until(REFRESH_DIV - 1, 3);

        // Decode sweep, one character per slot
        ovr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ovr_char = dec_tab[i].ch;
            run_until(BLANK_CYC, -1);
            check($sformatf("decode_%0h", i), seg, dec_tab[i].seg);
        end
        ovr_en = 1'b0;

        // Manual step, applied exactly at the next frame boundary
        run_until(3, 1);
        rot_dir = 1'b1;
        pulse();
        run_until(REFRESH_DIV - 1, 3);
        check("step_before_boundary", rot_counter, 0);
        tick();
        check("step_at_boundary", rot_counter, 1);
        run_until(BLANK_CYC, 0);
        check("step_digit0", seg, dec_tab[1].seg);
        run_until(BLANK_CYC, 3);
        check("step_digit3", seg, dec_tab[4].seg);

        // Two pulses in one frame advance by one
        run_until(3, 0);
        pulse();
        run_until(3, 2);
        pulse();
        run_until(REFRESH_DIV - 1, 3);
        tick();
        check("double_step", rot_counter, 2);
        run_until(REFRESH_DIV - 1, 3);
        tick();
        check("double_step_once", rot_counter, 2);

        // Wrap-around in both directions
        step_frame(1'b0);
        check("down_to_1", rot_counter, 1);
        step_frame(1'b0);
        check("down_to_0", rot_counter, 0);
        step_frame(1'b0);
        check("wrap_0_to_15", rot_counter, 15);
        run_until(BLANK_CYC, 0);
        check("wrap_digit0_F", seg, 7'b0001110);
        run_until(BLANK_CYC, 1);
        check("wrap_digit1_0", seg, 7'b1000000);
        step_frame(1'b1);
        check("wrap_15_to_0", rot_counter, 0);

        // Request on the applying edge while one is already pending
        rot_dir = 1'b1;
        run_until(3, 1);
        pulse();
        run_until(REFRESH_DIV - 1, 3);
        rot_step = 1'b1;
        tick();
        rot_step = 1'b0;
        check("collision_first", rot_counter, 1);
        run_until(REFRESH_DIV - 1, 3);
        check("collision_held", rot_counter, 1);
        tick();
        check("collision_second", rot_counter, 2);

        // Auto rotation: four timer requests in 400 unfrozen cycles
        freeze = 1'b0;
        repeat (400) tick();
        freeze = 1'b1;
        repeat (64) tick();
        check("auto_total", rot_counter, 6);
        repeat (150) tick();
        check("frozen_hold", rot_counter, 6);

        // Reset in the middle of a lit slot
        run_until(4, 1);
        reset = 1'b1;
        tick();
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_regSel", reg_sel, 0);
        check("midrst_rot", rot_counter, 0);
        reset = 1'b0;
        run_until(REFRESH_DIV - 1, 3);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
